// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin arbiter in front of a single shared A/B comparator.
// One requester is accepted per cycle and its compare result is held in an
// output register until the consumer takes it. Accepting a new request in the
// same cycle that the held result drains keeps throughput at one per cycle.
module cmp_share_arb #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ-1:0]         req_tc,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [5:0]              rsp_flags
);

   localparam logic [ID_W:0]    NREQ_W  = (ID_W+1)'(NREQ);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NREQ - 1);
   localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB_BIT = ONE_W << (WIDTH - 1);

   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_found;
   logic             grant_ok;
   logic             grant_en;
   logic [ID_W:0]    cand;

   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic             tc_sel;
   logic [WIDTH-1:0] a_key;
   logic [WIDTH-1:0] b_key;
   logic             cmp_lt;
   logic             cmp_gt;
   logic             cmp_eq;
   logic [5:0]       cmp_flags;

   // The output stage can accept when it is empty or is being drained this cycle;
   // reset keeps every ready low so nothing is handed over while rst_n is low.
   assign grant_ok = ~rsp_valid | rsp_ready;
   assign grant_en = rst_n & grant_ok & grant_found;

   // Round-robin search starting just above the last winner, wrapping at NREQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = {1'b0, last_grant} + (ID_W+1)'(k);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   // Ready is one-hot on the winner and depends only on valids, output state and pointer.
   always_comb begin
      req_ready = '0;
      if (grant_en) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Steer the winner's operands and compare mode onto the shared comparator.
   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      tc_sel = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            a_sel  = req_a[i*WIDTH +: WIDTH];
            b_sel  = req_b[i*WIDTH +: WIDTH];
            tc_sel = req_tc[i];
         end
      end
   end

   // Flipping the sign bit maps two's-complement ordering onto unsigned ordering,
   // so one magnitude comparator serves both modes.
   assign a_key     = a_sel ^ (tc_sel ? MSB_BIT : '0);
   assign b_key     = b_sel ^ (tc_sel ? MSB_BIT : '0);
   assign cmp_eq    = (a_sel == b_sel);
   assign cmp_lt    = (a_key < b_key);
   assign cmp_gt    = ~cmp_lt & ~cmp_eq;
   assign cmp_flags = {cmp_lt, cmp_gt, cmp_eq, cmp_lt | cmp_eq, cmp_gt | cmp_eq, ~cmp_eq};

   // Output register and arbitration pointer: load on a grant, clear on a drain
   // with no refill, otherwise hold so the consumer sees a stable result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_flags  <= 6'b000000;
         last_grant <= LAST_ID;
      end else begin
         if (grant_en) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_idx;
            rsp_flags  <= cmp_flags;
            last_grant <= grant_idx;
         end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cmp_share_arb.sv
// tb_cmp_share_arb: table-driven vectors, directed multi-cycle sequences and a
// randomized phase, all checked against a scoreboard fed by a reference model.
module tb_cmp_share_arb;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int ID_W  = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_tc;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [5:0]            rsp_flags;

   typedef struct {
      int         id;
      logic [5:0] flags;
   } sb_item_t;

   typedef struct {
      int         req;
      logic [7:0] a;
      logic [7:0] b;
      logic       tc;
      logic [5:0] exp_flags;
   } vec_t;

   sb_item_t sb[$];
   vec_t     vecs[9];
   int       n_cmp = 0;
   int       n_bad = 0;
   int       m_last;
   int       m_win;
   int       wait_cnt[NREQ];
   int       max_wait;
   logic [NREQ-1:0] exp_ready;
   sb_item_t        item;

   always #5 clk = ~clk;

   cmp_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tc    (req_tc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_flags (rsp_flags)
   );

   // Reference compare using native signed/unsigned relational operators.
   function automatic logic [5:0] refFlags(input logic [7:0] a, input logic [7:0] b, input logic tc);
      logic lt;
      logic gt;
      logic eq;
      if (tc) lt = ($signed(a) < $signed(b));
      else    lt = (a < b);
      eq = (a == b);
      gt = !lt && !eq;
      return {lt, gt, eq, lt | eq, gt | eq, !eq};
   endfunction

   function automatic logic flagsConsistent(input logic [5:0] f);
      return (f[0] == ~f[3]) && (f[2] == (f[5] | f[3])) && (f[1] == (f[4] | f[3]))
             && ($countones(f[5:3]) == 1);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] tc,
                                input logic [31:0] a, input logic [31:0] b, input logic rdy);
      req_valid = v;
      req_tc    = tc;
      req_a     = a;
      req_b     = b;
      rsp_ready = rdy;
   endtask

   task automatic doReset(input logic [NREQ-1:0] v_after, input logic rdy_after);
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_valid = v_after;
      rsp_ready = rdy_after;
      rst_n     = 1'b1;
   endtask

   // Cycle model: predicts the grant, pushes the expected result when a request
   // is accepted and compares the held result until the consumer takes it.
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
         checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
         checkOutput("rst_rsp_id",    64'(rsp_id),    64'(0));
         checkOutput("rst_rsp_flags", 64'(rsp_flags), 64'(0));
         sb.delete();
         m_last = NREQ - 1;
         for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      end else begin
         m_win = -1;
         if (sb.size() == 0 || rsp_ready) begin
            for (int k = 1; k <= NREQ; k++) begin
               int c;
               c = (m_last + k) % NREQ;
               if (m_win < 0 && req_valid[c[1:0]]) m_win = c;
            end
         end
         exp_ready = (m_win >= 0) ? NREQ'(32'd1 << m_win) : '0;
         checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
         checkOutput("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
         if (sb.size() != 0) begin
            checkOutput("rsp_id",    64'(rsp_id),    64'(sb[0].id));
            checkOutput("rsp_flags", 64'(rsp_flags), 64'(sb[0].flags));
            checkOutput("flag_rules", 64'(flagsConsistent(rsp_flags)), 64'(1));
            if (rsp_ready) void'(sb.pop_front());
         end
         if (m_win >= 0) begin
            item.id    = m_win;
            item.flags = refFlags(req_a[m_win*WIDTH +: WIDTH], req_b[m_win*WIDTH +: WIDTH], req_tc[m_win]);
            sb.push_back(item);
            m_last   = m_win;
            max_wait = 0;
            for (int i = 0; i < NREQ; i++) begin
               if (i == m_win || !req_valid[i]) wait_cnt[i] = 0;
               else wait_cnt[i]++;
               if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            checkOutput("starvation", 64'(max_wait >= NREQ), 64'(0));
         end
      end
   end

   // Directed sequences, vector table and randomized traffic.
   initial begin
      logic [31:0] av;
      logic [31:0] bv;
      logic [31:0] tv;
      logic [NREQ-1:0] onehot;

      vecs[0] = '{2, 8'hF0, 8'h0F, 1'b0, 6'b010011};
      vecs[1] = '{2, 8'hF0, 8'h0F, 1'b1, 6'b100101};
      vecs[2] = '{1, 8'h80, 8'h80, 1'b1, 6'b001110};
      vecs[3] = '{0, 8'h80, 8'h80, 1'b0, 6'b001110};
      vecs[4] = '{3, 8'h7F, 8'h80, 1'b1, 6'b010011};
      vecs[5] = '{3, 8'h7F, 8'h80, 1'b0, 6'b100101};
      vecs[6] = '{0, 8'h00, 8'hFF, 1'b1, 6'b010011};
      vecs[7] = '{1, 8'hFF, 8'hFE, 1'b1, 6'b010011};
      vecs[8] = '{1, 8'h01, 8'h02, 1'b0, 6'b100101};

      applyStimulus('1, '0, '0, '0, 1'b0);
      doReset('0, 1'b1);

      // One isolated request per vector; result expected one cycle later.
      for (int i = 0; i < 9; i++) begin
         av = $urandom;
         bv = $urandom;
         av[vecs[i].req*8 +: 8] = vecs[i].a;
         bv[vecs[i].req*8 +: 8] = vecs[i].b;
         onehot = NREQ'(32'd1 << vecs[i].req);
         applyStimulus(onehot, vecs[i].tc ? onehot : '0, av, bv, 1'b1);
         @(posedge clk); #1;
         applyStimulus('0, '0, av, bv, 1'b1);
         @(negedge clk);
         checkOutput("vec_valid", 64'(rsp_valid), 64'(1));
         checkOutput("vec_id",    64'(rsp_id),    64'(vecs[i].req));
         checkOutput("vec_flags", 64'(rsp_flags), 64'(vecs[i].exp_flags));
         @(posedge clk); #1;
      end

      // All requesters valid after reset: strict 0,1,2,3 rotation, one result per cycle.
      applyStimulus('0, 4'b0101, $urandom, $urandom, 1'b1);
      doReset('1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("rr_ready", 64'(req_ready), 64'(32'd1 << (k % 4)));
         if (k > 0) begin
            checkOutput("rr_valid", 64'(rsp_valid), 64'(1));
            checkOutput("rr_id",    64'(rsp_id),    64'((k - 1) % 4));
         end
      end

      // Backpressure: result from requester 3 must hold and no grant may occur.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         checkOutput("bp_ready", 64'(req_ready), 64'(0));
         checkOutput("bp_valid", 64'(rsp_valid), 64'(1));
         checkOutput("bp_id",    64'(rsp_id),    64'(3));
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_refill_ready", 64'(req_ready), 64'(4'b0001));
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("bp_refill_id", 64'(rsp_id), 64'(0));

      // Reset while a result is stuck: it must vanish without a clock edge.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("pend_valid", 64'(rsp_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("async_valid", 64'(rsp_valid), 64'(0));
      checkOutput("async_ready", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      rst_n     = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_ready", 64'(req_ready), 64'(4'b0001));
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("post_rst_id", 64'(rsp_id), 64'(0));

      // Random traffic; equal operands are forced often enough to hit EQ.
      for (int n = 0; n < 10000; n++) begin
         @(posedge clk); #1;
         av = $urandom;
         bv = $urandom;
         tv = $urandom;
         for (int s = 0; s < NREQ; s++) begin
            if ($urandom_range(3) == 0) bv[s*8 +: 8] = av[s*8 +: 8];
         end
         applyStimulus(NREQ'($urandom), tv[NREQ-1:0], av, bv, $urandom_range(9) < 7);
      end

      @(posedge clk); #1;
      applyStimulus('0, '0, '0, '0, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("sb_empty", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cmp_share_arb.md
CMP_SHARE_ARB -- requirements
Module: cmp_share_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters, legal range 2..8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: bit i set means requester i presents an operand pair.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: bit i set means requester i's pair is accepted this cycle.
REQ-007 The block SHALL have port req_a, input, NREQ*WIDTH bits: operand A, with requester i at bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_b, input, NREQ*WIDTH bits: operand B, packed the same way as req_a.
REQ-009 The block SHALL have port req_tc, input, NREQ bits: bit i = 1 selects two's-complement compare for requester i; 0 selects unsigned.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a result is held in the output register.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result when both rsp_valid and rsp_ready are 1.
REQ-012 The block SHALL have port rsp_id, output, max(1,clog2(NREQ)) bits: index of the requester that owns the result.
REQ-013 The block SHALL have port rsp_flags, output, 6 bits: {LT,GT,EQ,LE,GE,NE} from comparing A with B.

Function
REQ-014 Only one comparator SHALL exist; at most one req_ready bit SHALL be 1 in any cycle.
REQ-015 A grant is allowed SHALL hold when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 (same-cycle drain-and-refill).
REQ-016 When a grant is allowed and any req_valid bit is 1, the block SHALL assert req_ready for exactly one winner, chosen round-robin; otherwise req_ready SHALL be all zero.
REQ-017 Round-robin priority SHALL start at index (last_grant+1) mod NREQ and search upward with wrap-around.
REQ-018 last_grant SHALL update only on a completed grant (req_valid[i] & req_ready[i]).
REQ-019 req_ready SHALL be combinational from req_valid, rsp_valid, rsp_ready and the pointer only; it SHALL NOT depend on operand data.
REQ-020 On a grant in cycle N, the output register SHALL load that requester's result, with rsp_id set to the winner index, and rsp_valid SHALL be 1 in cycle N+1 (latency 1).
REQ-021 With tc=0, A and B SHALL be compared as unsigned; with tc=1, as WIDTH-bit two's complement.
REQ-022 The flags SHALL always satisfy EQ=~NE, LE=LT|EQ, GE=GT|EQ, and exactly one of LT, GT, EQ SHALL be set.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_flags and rsp_id SHALL hold stable and no grant SHALL occur.
REQ-024 When the output is drained (rsp_valid=1, rsp_ready=1) and no requester is valid, rsp_valid SHALL be 0 in the next cycle.
REQ-025 A requester that holds req_valid=1 SHALL be granted within NREQ grants, so no requester can starve.
REQ-026 A requester that drops req_valid before being granted SHALL NOT be granted, and the block SHALL NOT treat this as an error.

Reset
REQ-027 While rst_n=0: rsp_valid=0, rsp_id=0, rsp_flags=6'b000000, req_ready all zero, and last_grant=NREQ-1, so requester 0 has first priority after reset.
REQ-028 A reset asserted while a result is pending SHALL discard that result immediately, without waiting for a clock edge.
REQ-029 The first rising clk edge at which rst_n is sampled high SHALL be able to grant a request.

Verification
REQ-030 Unsigned compare: req 2 valid, A=8'hF0, B=8'h0F, tc=0 -> next cycle rsp_valid=1, rsp_id=2, flags={0,1,0,0,1,1}.
REQ-031 Signed compare: same operands with tc=1 -> flags={1,0,0,1,0,1}. Equal case: A=B=8'h80 -> flags={0,0,1,1,1,0}.
REQ-032 Fairness: all 4 requesters valid continuously with rsp_ready=1 -> after reset, grants occur in order 0,1,2,3,0,1..., with one result every cycle.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles while requests are pending -> req_ready stays all zero and the output holds stable; rsp_ready=1 -> the next grant lands in the same cycle as the drain.
REQ-034 Reset mid-operation: rst_n pulled low while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately; after release, requester 0 wins when all requesters are valid.
REQ-035 Randomized check: random valid/ready/operands/tc for 10k cycles -> flags match a reference model, the flag invariants of REQ-022 hold, no more than one req_ready bit is ever 1, and no requester waits more than NREQ grants.
